// File: rtl/transmit_receive.sv
// Bit-per-clock serial link: 8-bit even-parity framed transmitter plus matching receiver.
// Frame: start 0, data LSB first, parity (^data), stop 1.
module transmit_receive (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  input  logic       rx,
  output logic [7:0] out,
  output logic       par,
  output logic       valid,
  output logic       par_err,
  output logic       frame_err
);

  localparam int unsigned DW = 8;
  localparam int unsigned IW = 3;
  localparam logic [IW-1:0] LAST_IDX = IW'(DW - 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

  tx_state_e     tx_state, tx_next;
  logic [DW-1:0] tx_word;
  logic [IW-1:0] tx_idx, tx_idx_next;
  logic          tx_accept_c;
  logic          tx_d, busy_d;

  rx_state_e     rx_state, rx_next;
  logic [DW-1:0] rx_word;
  logic [IW-1:0] rx_idx, rx_idx_next;
  logic          rx_par;
  logic          valid_d, frame_err_d;

  // Transmitter state, captured word and registered line outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= TX_IDLE;
      tx_idx   <= '0;
      tx_word  <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else begin
      tx_state <= tx_next;
      tx_idx   <= tx_idx_next;
      tx       <= tx_d;
      busy     <= busy_d;
      if (tx_accept_c) tx_word <= data;
    end
  end

  // STOP may accept a new start directly so held start gives gap-free frames
  always_comb begin
    tx_next     = tx_state;
    tx_idx_next = tx_idx;
    tx_accept_c = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (start) begin
          tx_next     = TX_START;
          tx_accept_c = 1'b1;
        end
      end
      TX_START: begin
        tx_next     = TX_DATA;
        tx_idx_next = '0;
      end
      TX_DATA: begin
        if (tx_idx == LAST_IDX) tx_next = TX_PARITY;
        else tx_idx_next = IW'(tx_idx + 1'b1);
      end
      TX_PARITY: tx_next = TX_STOP;
      TX_STOP: begin
        if (start) begin
          tx_next     = TX_START;
          tx_accept_c = 1'b1;
        end else begin
          tx_next = TX_IDLE;
        end
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  // Line value for the state being entered, registered on the same edge
  always_comb begin
    tx_d   = 1'b1;
    busy_d = 1'b1;
    case (tx_next)
      TX_IDLE:   busy_d = 1'b0;
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = tx_word[tx_idx_next];
      TX_PARITY: tx_d = ^tx_word;
      TX_STOP:   tx_d = 1'b1;
      default:   busy_d = 1'b0;
    endcase
  end

  // Receiver state, shift register and delivered word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state  <= RX_IDLE;
      rx_idx    <= '0;
      rx_word   <= '0;
      rx_par    <= 1'b0;
      out       <= '0;
      par       <= 1'b0;
      par_err   <= 1'b0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_state  <= rx_next;
      rx_idx    <= rx_idx_next;
      valid     <= valid_d;
      frame_err <= frame_err_d;
      if (rx_state == RX_DATA) rx_word <= {rx, rx_word[DW-1:1]};
      if (rx_state == RX_PARITY) rx_par <= rx;
      if (valid_d) begin
        out     <= rx_word;
        par     <= rx_par;
        par_err <= rx_par ^ (^rx_word);
      end
    end
  end

  always_comb begin
    rx_next     = rx_state;
    rx_idx_next = rx_idx;
    case (rx_state)
      RX_IDLE: begin
        if (!rx) begin
          rx_next     = RX_DATA;
          rx_idx_next = '0;
        end
      end
      RX_DATA: begin
        if (rx_idx == LAST_IDX) rx_next = RX_PARITY;
        else rx_idx_next = IW'(rx_idx + 1'b1);
      end
      RX_PARITY: rx_next = RX_STOP;
      RX_STOP:   rx_next = RX_IDLE;
      default:   rx_next = RX_IDLE;
    endcase
  end

  // Stop bit decides between delivering the word and flagging a framing error
  always_comb begin
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
    if (rx_state == RX_STOP) begin
      valid_d     = rx;
      frame_err_d = ~rx;
    end
  end

endmodule

// File: tb/tb_transmit_receive.sv
// Self-checking bench for transmit_receive: loopback and direct-rx frames vs. a frame-level model.
module tb_transmit_receive;

  logic       clk = 1'b0;
  logic       rst, start, rx, tx, busy, par, valid, par_err, frame_err;
  logic [7:0] data, out;
  logic       loop, rx_drv;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard of what the receiver should be holding
  logic [7:0] m_out;
  logic       m_par, m_perr;

  always #5 clk = ~clk;
  assign rx = loop ? tx : rx_drv;

  transmit_receive dut (
    .clk(clk), .rst(rst), .start(start), .data(data), .tx(tx), .busy(busy), .rx(rx),
    .out(out), .par(par), .valid(valid), .par_err(par_err), .frame_err(frame_err)
  );

  // Bit i is the line value after edge k+i, k being the accept edge
  function automatic logic [10:0] frame_of(input logic [7:0] d, input logic p, input logic s);
    return {s, p, d, 1'b0};
  endfunction

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; data = 8'h00; loop = 1'b1; rx_drv = 1'b1;
    m_out = 8'h00; m_par = 1'b0; m_perr = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({tx, busy, out, par, valid, par_err, frame_err} !== {1'b1, 1'b0, 8'h00, 4'b0000}) begin
      n_fail++;
      $display("FAIL reset_hold: tx/busy/out/par/valid/perr/ferr=%b/%b/%h/%b/%b/%b/%b required 1/0/00/0/0/0/0",
               tx, busy, out, par, valid, par_err, frame_err);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({tx, busy, valid, frame_err} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_release: tx/busy/valid/ferr=%b required 1000", {tx, busy, valid, frame_err});
    end
  endtask

  task automatic send_loop(input logic [7:0] d, input string name);
    logic [10:0] f;
    f = frame_of(d, ^d, 1'b1);
    loop = 1'b1; start = 1'b1; data = d;
    @(negedge clk);
    start = 1'b0; data = 8'($urandom);
    for (int i = 0; i < 11; i++) begin
      n_checks++;
      if ({tx, busy, valid} !== {f[i], 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL %s bit%0d: tx/busy/valid=%b required %b", name, i, {tx, busy, valid}, {f[i], 2'b10});
      end
      @(negedge clk);
    end
    m_out = d; m_par = ^d; m_perr = 1'b0;
    n_checks++;
    if ({tx, busy, valid, out, par, par_err, frame_err} !== {1'b1, 1'b0, 1'b1, m_out, m_par, m_perr, 1'b0}) begin
      n_fail++;
      $display("FAIL %s deliver: tx/busy/valid=%b out=%h par=%b perr=%b ferr=%b required 101 out=%h par=%b perr=0 ferr=0",
               name, {tx, busy, valid}, out, par, par_err, frame_err, m_out, m_par);
    end
    @(negedge clk);
    n_checks++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s valid_pulse: valid=%b required 0", name, valid);
    end
  endtask

  task automatic test_loopback_known;
    send_loop(8'h4C, "lb_4C");
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m_out = 8'h00; m_par = 1'b0; m_perr = 1'b0;
    @(negedge clk);
    send_loop(8'h4E, "lb_4E");
    send_loop(8'h00, "lb_00");
    send_loop(8'hFF, "lb_FF");
  endtask

  task automatic test_random_loopback;
    logic [7:0] d;
    for (int n = 0; n < 8; n++) begin
      d = 8'($urandom);
      send_loop(d, "lb_rand");
    end
  endtask

  task automatic test_back_to_back;
    logic [10:0] f;
    int          vcount;
    logic        exp_tx, exp_busy, exp_valid;
    f = frame_of(8'hA5, ^(8'hA5), 1'b1);
    vcount = 0;
    loop = 1'b1; start = 1'b1; data = 8'hA5;
    @(negedge clk);
    for (int c = 0; c < 40; c++) begin
      exp_tx    = (c < 33) ? f[c % 11] : 1'b1;
      exp_busy  = (c < 33);
      exp_valid = (c == 11) || (c == 22) || (c == 33);
      n_checks++;
      if ({tx, busy, valid} !== {exp_tx, exp_busy, exp_valid}) begin
        n_fail++;
        $display("FAIL b2b cycle%0d: tx/busy/valid=%b required %b", c, {tx, busy, valid}, {exp_tx, exp_busy, exp_valid});
      end
      if (valid === 1'b1) vcount++;
      if (c == 22) start = 1'b0;
      @(negedge clk);
    end
    m_out = 8'hA5; m_par = ^(8'hA5); m_perr = 1'b0;
    n_checks++;
    if (vcount != 3 || out !== m_out) begin
      n_fail++;
      $display("FAIL b2b summary: valid pulses=%0d out=%h required 3 out=%h", vcount, out, m_out);
    end
  endtask

  task automatic test_start_ignored;
    logic [10:0] f;
    f = frame_of(8'h4C, ^(8'h4C), 1'b1);
    loop = 1'b1; start = 1'b1; data = 8'h4C;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 11; i++) begin
      n_checks++;
      if ({tx, busy} !== {f[i], 1'b1}) begin
        n_fail++;
        $display("FAIL ignore bit%0d: tx/busy=%b required %b", i, {tx, busy}, {f[i], 1'b1});
      end
      if (i == 4) begin start = 1'b1; data = 8'hFF; end
      if (i == 5) start = 1'b0;
      @(negedge clk);
    end
    m_out = 8'h4C; m_par = 1'b1; m_perr = 1'b0;
    n_checks++;
    if ({valid, out, par} !== {1'b1, m_out, m_par}) begin
      n_fail++;
      $display("FAIL ignore deliver: valid=%b out=%h par=%b required 1 %h %b", valid, out, par, m_out, m_par);
    end
    @(negedge clk);
    n_checks++;
    if ({tx, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL ignore no_queue: tx/busy=%b required 10", {tx, busy});
    end
  endtask

  task automatic rx_frame(input logic [7:0] d, input logic p, input logic s, input string name);
    logic [10:0] b;
    b = frame_of(d, p, s);
    loop = 1'b0;
    for (int i = 0; i < 11; i++) begin
      rx_drv = b[i];
      @(negedge clk);
      if (i < 10) begin
        n_checks++;
        if ({valid, frame_err} !== 2'b00) begin
          n_fail++;
          $display("FAIL %s early bit%0d: valid/ferr=%b required 00", name, i, {valid, frame_err});
        end
      end
    end
    rx_drv = 1'b1;
    if (s) begin
      m_out = d; m_par = p; m_perr = p ^ (^d);
    end
    n_checks++;
    if ({valid, frame_err, out, par, par_err} !== {s, ~s, m_out, m_par, m_perr}) begin
      n_fail++;
      $display("FAIL %s stop: valid=%b ferr=%b out=%h par=%b perr=%b required %b %b %h %b %b",
               name, valid, frame_err, out, par, par_err, s, ~s, m_out, m_par, m_perr);
    end
    @(negedge clk);
    n_checks++;
    if ({valid, frame_err} !== 2'b00) begin
      n_fail++;
      $display("FAIL %s pulse_width: valid/ferr=%b required 00", name, {valid, frame_err});
    end
  endtask

  task automatic test_rx_direct;
    rx_frame(8'h4C, 1'b0, 1'b1, "rx_perr_4C");
    rx_frame(8'h3A, ^(8'h3A), 1'b0, "rx_frame_err");
    rx_frame(8'h96, 1'b0, 1'b1, "rx_good_96");
  endtask

  task automatic test_rx_random;
    logic [7:0] d;
    logic       p, s;
    for (int n = 0; n < 10; n++) begin
      d = 8'($urandom);
      p = 1'($urandom);
      s = ($urandom_range(0, 3) != 0);
      rx_frame(d, p, s, "rx_rand");
    end
    loop = 1'b1;
  endtask

  task automatic test_reset_mid_frame;
    loop = 1'b1; start = 1'b1; data = 8'h4C;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    m_out = 8'h00; m_par = 1'b0; m_perr = 1'b0;
    n_checks++;
    if ({tx, busy, valid, frame_err, out, par, par_err} !== {4'b1000, m_out, m_par, m_perr}) begin
      n_fail++;
      $display("FAIL midreset: tx/busy/valid/ferr=%b out=%h par=%b perr=%b required 1000 00 0 0",
               {tx, busy, valid, frame_err}, out, par, par_err);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      n_checks++;
      if ({tx, busy, valid, frame_err} !== 4'b1000) begin
        n_fail++;
        $display("FAIL midreset after%0d: tx/busy/valid/ferr=%b required 1000", c, {tx, busy, valid, frame_err});
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_loopback_known();
    test_random_loopback();
    test_back_to_back();
    test_start_ignored();
    test_rx_direct();
    test_rx_random();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
